// File: rtl/cpc_lowrom_bank_ctrl.sv
// Lower-ROM socket controller: CPU-writable bank/disable/write-enable register behind an I/O port.
// Optional readback of the control register is built when LOWROM_READBACK_EN is defined.
module cpc_lowrom_bank_ctrl #(
    parameter logic [7:0] IO_PORT_HI  = 8'hFC,
    parameter int         BANK_W      = 1,
    parameter logic [7:0] ARM_KEY     = 8'hA5,
    parameter int         ARM_TIMEOUT = 1023
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic [15:0]       A,
    input  logic [7:0]        D,
    input  logic              IOREQ_B,
    input  logic              MREQ_B,
    input  logic              RD_B,
    input  logic              WR_B,
    input  logic              ROMEN_B,
    input  logic              disable_link,  // hardware "disable" link; the plain name is a reserved word
    output logic              romcs_b,
    output logic              romdis,
    output logic [BANK_W-1:0] rom_bank,
    output logic              rom_we_b,
    output logic [7:0]        d_out,
    output logic              d_oe
);

    localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [BANK_W-1:0] r_bank, w_bank_nxt;
    logic              r_wren, w_wren_nxt;
    logic              r_soft_dis, w_soft_dis_nxt;
    logic              r_iowr_q;
    logic              w_iowr, w_event, w_off;
    logic              w_unused;

    assign w_iowr  = !IOREQ_B && !WR_B && (A[15:8] == IO_PORT_HI);
    // One event per I/O cycle: only the first sampled edge of a long (wait-stated) strobe counts.
    assign w_event = w_iowr && !r_iowr_q;

    always_comb begin
        // NOTE: every next-state signal is defaulted to its register first so no path infers a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bank_nxt     = r_bank;
        w_wren_nxt     = r_wren;
        w_soft_dis_nxt = r_soft_dis;
        case (r_state)
            IDLE: begin
                if (w_event) begin
                    if (D == ARM_KEY) begin
                        w_state_nxt = ARMED;
                        w_cnt_nxt   = CNT_W'(ARM_TIMEOUT);
                    end else begin
                        w_bank_nxt     = D[BANK_W-1:0];
                        w_soft_dis_nxt = D[7];
                        w_wren_nxt     = 1'b0;
                    end
                end
            end
            ARMED: begin
                // A write on the expiry cycle still counts as the armed write.
                if (w_event) begin
                    w_bank_nxt     = D[BANK_W-1:0];
                    w_soft_dis_nxt = D[7];
                    w_wren_nxt     = D[6];
                    w_state_nxt    = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bank     <= '0;
            r_wren     <= 1'b0;
            r_soft_dis <= 1'b0;
            r_iowr_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bank     <= w_bank_nxt;
            r_wren     <= w_wren_nxt;
            r_soft_dis <= w_soft_dis_nxt;
            r_iowr_q   <= w_iowr;
        end
    end

    assign w_off    = disable_link || r_soft_dis;
    assign romcs_b  = ROMEN_B || A[14] || w_off;
    assign romdis   = !A[14] && !w_off;
    assign rom_bank = r_bank;
    // Purely combinational so the programming pulse tracks the Z80 write strobe exactly.
    assign rom_we_b = !(r_wren && !w_off && !MREQ_B && !WR_B && !A[15] && !A[14]);

`ifdef LOWROM_READBACK_EN
    logic [7:0] r_d_out;
    logic [3:0] w_bank4;

    assign w_bank4 = 4'(r_bank);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_d_out <= 8'h00;
        end else begin
            r_d_out <= {r_soft_dis, r_wren, (r_state == ARMED), disable_link, w_bank4};
        end
    end

    assign d_out = r_d_out;
    assign d_oe  = !IOREQ_B && !RD_B && (A[15:8] == IO_PORT_HI);
`else
    assign d_out = 8'h00;
    assign d_oe  = 1'b0;
`endif

    assign w_unused = ^{RD_B, A[13:0], D};

endmodule

// File: tb/tb_cpc_lowrom_bank_ctrl.sv
// Self-checking bench for cpc_lowrom_bank_ctrl: directed steps plus randomized port writes
// compared against an edge-count based model of the control register.
module tb_cpc_lowrom_bank_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_B;
    logic [15:0] A;
    logic [7:0]  D;
    logic        IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B, disable_link;
    logic        romcs_b, romdis, rom_we_b, d_oe;
    logic [0:0]  rom_bank;
    logic [7:0]  d_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: register contents plus the edge number at which the port was armed.
    logic [0:0] m_bank;
    logic       m_wren, m_soft, m_armed;
    int         m_arm_e;

    cpc_lowrom_bank_ctrl dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D), .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B),
        .RD_B(RD_B), .WR_B(WR_B), .ROMEN_B(ROMEN_B), .disable_link(disable_link),
        .romcs_b(romcs_b), .romdis(romdis), .rom_bank(rom_bank), .rom_we_b(rom_we_b),
        .d_out(d_out), .d_oe(d_oe)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic model_reset();
        m_bank  = '0;
        m_wren  = 1'b0;
        m_soft  = 1'b0;
        m_armed = 1'b0;
        m_arm_e = 0;
    endtask

    // Armed window: the port stays armed for ARM_TIMEOUT+1 edges after the arming edge.
    function automatic logic armed_after(input int e);
        return m_armed && ((e - m_arm_e) <= 1023);
    endfunction

    task automatic model_event(input logic [7:0] d, input int e);
        if (armed_after(e - 1)) begin
            m_bank  = d[0];
            m_soft  = d[7];
            m_wren  = d[6];
            m_armed = 1'b0;
        end else if (d == 8'hA5) begin
            m_armed = 1'b1;
            m_arm_e = e;
        end else begin
            m_bank  = d[0];
            m_soft  = d[7];
            m_wren  = 1'b0;
            m_armed = 1'b0;
        end
    endtask

    task automatic bus_idle();
        IOREQ_B = 1'b1;
        MREQ_B  = 1'b1;
        RD_B    = 1'b1;
        WR_B    = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] d, input int waits);
        A       = {8'hFC, 8'($urandom)};
        D       = d;
        IOREQ_B = 1'b0;
        WR_B    = 1'b0;
        #1 check("io_bank_before_edge", rom_bank, m_bank);
        cycle();
        model_event(d, cyc);
        check("io_bank_after_edge", rom_bank, m_bank);
        repeat (waits) cycle();
        bus_idle();
        D = 8'($urandom);
        cycle();
    endtask

    task automatic mem_we(input string tag, input logic [15:0] addr, input logic exp);
        A      = addr;
        MREQ_B = 1'b0;
        WR_B   = 1'b0;
        #1 check(tag, rom_we_b, exp);
        bus_idle();
        #1 check({tag, "_released"}, rom_we_b, 1'b1);
    endtask

    task automatic check_outputs(input string tag);
        logic off;
        for (int i = 0; i < 3; i++) begin
            A       = 16'($urandom);
            if (i == 0) A[15:14] = 2'b00;
            ROMEN_B = 1'($urandom);
            MREQ_B  = 1'($urandom);
            WR_B    = 1'($urandom);
            IOREQ_B = 1'b1;
            #1;
            off = disable_link | m_soft;
            check({tag, "_romcs_b"}, romcs_b, ROMEN_B | A[14] | off);
            check({tag, "_romdis"}, romdis, !A[14] & !off);
            check({tag, "_rom_bank"}, rom_bank, m_bank);
            check({tag, "_rom_we_b"}, rom_we_b,
                  !(m_wren & !off & !MREQ_B & !WR_B & !A[15] & !A[14]));
            check({tag, "_d_oe"}, d_oe, 1'b0);
        end
        bus_idle();
        ROMEN_B = 1'b0;
`ifdef LOWROM_READBACK_EN
        IOREQ_B = 1'b0;
        RD_B    = 1'b0;
        A       = 16'hFC00;
        #1 check({tag, "_rb_oe"}, d_oe, 1'b1);
        check({tag, "_rb_data"}, d_out,
              {m_soft, m_wren, armed_after(cyc - 1), disable_link, 3'b000, m_bank});
        bus_idle();
`else
        #1 check({tag, "_d_out"}, d_out, 8'h00);
`endif
    endtask

    initial begin
        int gap;
        logic [7:0] d;

        bus_idle();
        A            = 16'h0100;
        D            = 8'h00;
        ROMEN_B      = 1'b0;
        disable_link = 1'b0;
        RESET_B      = 1'b0;
        model_reset();

        // Reset state.
        #2;
        check("rst_romcs_b", romcs_b, 1'b0);
        check("rst_romdis", romdis, 1'b1);
        check("rst_rom_bank", rom_bank, 1'b0);
        check("rst_rom_we_b", rom_we_b, 1'b1);
        check("rst_d_oe", d_oe, 1'b0);
        repeat (2) cycle();
        RESET_B = 1'b1;
        cycle();

        // Plain bank select; write-enable stays off.
        io_write(8'h01, 0);
        check("bank_one", rom_bank, 1'b1);
        mem_we("we_blocked_0200", 16'h0200, 1'b1);
        check_outputs("after_bank1");

        // Arm then write with D[6] set: programming enabled only in the lower 16K.
        io_write(8'hA5, 1);
        repeat ($urandom_range(0, 900)) cycle();
        io_write(8'h41, 2);
        mem_we("we_active_1000", 16'h1000, 1'b0);
        mem_we("we_upper_4000", 16'h4000, 1'b1);
        check_outputs("after_arm_write");

        // Arming expired: the write is treated as an ordinary IDLE write.
        io_write(8'hA5, 0);
        while (cyc < m_arm_e + 1024) cycle();
        io_write(8'h40, 0);
        mem_we("we_after_timeout", 16'h1000, 1'b1);

        // Write lands on the very edge the counter reaches zero: still armed.
        io_write(8'hA5, 0);
        while (cyc < m_arm_e + 1023) cycle();
        io_write(8'h40, 0);
        mem_we("we_at_boundary", 16'h1000, 1'b0);

        // Soft disable survives hardware disable toggling.
        io_write(8'h80, 0);
        A = 16'h0000;
        #1 check("soft_off_romcs_b", romcs_b, 1'b1);
        check("soft_off_romdis", romdis, 1'b0);
        disable_link = 1'b1;
        cycle();
        disable_link = 1'b0;
        cycle();
        A = 16'h0000;
        #1 check("still_off_romcs_b", romcs_b, 1'b1);
        check("still_off_romdis", romdis, 1'b0);
        io_write(8'h00, 0);
        A = 16'h0000;
        #1 check("restored_romcs_b", romcs_b, 1'b0);
        check("restored_romdis", romdis, 1'b1);

        // Randomized sequence of port writes, gaps and hardware disable changes.
        for (int n = 0; n < 40; n++) begin
            d = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
            if ($urandom_range(0, 5) == 0) disable_link = ~disable_link;
            io_write(d, $urandom_range(0, 3));
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1015, 1030) : $urandom_range(0, 4);
            repeat (gap) cycle();
            check_outputs("rand");
        end
        disable_link = 1'b0;
        cycle();

        // Reset in the middle of an armed port write clears everything.
        io_write(8'hA5, 0);
        io_write(8'h41, 0);
        io_write(8'hA5, 0);
        A       = 16'hFC00;
        D       = 8'hC3;
        IOREQ_B = 1'b0;
        WR_B    = 1'b0;
        #2 RESET_B = 1'b0;
        model_reset();
        #1 check("midrst_bank", rom_bank, 1'b0);
        bus_idle();
        mem_we("midrst_we", 16'h1000, 1'b1);
        repeat (2) cycle();
        RESET_B = 1'b1;
        cycle();
        check_outputs("post_reset");
        io_write(8'h41, 0);
        mem_we("post_reset_idle_write", 16'h1000, 1'b1);

        // Reset during a memory write drops the programming strobe immediately.
        io_write(8'hA5, 0);
        io_write(8'h41, 0);
        A      = 16'h1000;
        MREQ_B = 1'b0;
        WR_B   = 1'b0;
        #1 check("memrst_we_before", rom_we_b, 1'b0);
        RESET_B = 1'b0;
        model_reset();
        #1 check("memrst_we_after", rom_we_b, 1'b1);
        bus_idle();
        cycle();
        RESET_B = 1'b1;
        cycle();
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
